tape_stream_reader: RTL and testbench

- Upstream client of the SDRAM controller's tape port (tape_addr / tape_rd / tape_dout / tape_ack).
- Streams a byte range of the tape image held in SDRAM bank 2 into a small local FIFO.
- The tape playback/pulse generator pops bytes from the FIFO at its own rate.
- Keeps at most one SDRAM tape request in flight and obeys the controller's toggle-acknowledge protocol.

---
 rtl/tape_stream_reader.sv | 187 ++++++++++++++++++
 tb/tb_tape_stream_reader.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tape_stream_reader.sv
// tape_stream_reader: streams a byte range of the tape image from the SDRAM
// controller's tape port into a small local FIFO. One request is kept in
// flight at a time, and the controller's toggle-acknowledge is tracked
// against a local copy of the last seen ack phase.
module tape_stream_reader #(
    parameter int DEPTH = 8,
    parameter int AW    = 23
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          abort,
    input  logic [AW-1:0] base_addr,
    input  logic [AW-1:0] length,
    output logic [AW-1:0] tape_addr,
    output logic          tape_rd,
    input  logic [7:0]    tape_dout,
    input  logic          tape_ack,
    input  logic          pop,
    output logic [7:0]    byte_out,
    output logic          byte_valid,
    output logic          busy,
    output logic          done
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_WAIT  = 3'd1;
    localparam logic [2:0] S_FETCH = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]    state, state_nxt;
    logic          ack_seen;
    logic          ack_evt;
    logic [AW-1:0] remaining;

    logic [7:0]    mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr, rd_nxt;
    logic [PW:0]   count, count_ap;
    logic          pop_eff;
    logic [7:0]    head_nxt;

    logic          push, flush, load, advance, set_done, clr_done;

    // A toggle of tape_ack relative to the last seen phase marks a finished access.
    assign ack_evt = (tape_ack != ack_seen);
    // Request drops in the ack cycle so the controller never re-issues the read.
    assign tape_rd = (state == S_FETCH) && !ack_evt;
    assign busy    = (state == S_WAIT) || (state == S_FETCH) || (state == S_DRAIN);

    assign byte_valid = (count != '0);
    assign pop_eff    = pop && (count != '0);
    assign count_ap   = count - {{PW{1'b0}}, pop_eff};
    assign rd_nxt     = rd_ptr + PW'(pop_eff);

    // Next-state and control strobes; abort takes priority over start.
    always_comb begin
        state_nxt = state;
        push      = 1'b0;
        flush     = 1'b0;
        load      = 1'b0;
        advance   = 1'b0;
        set_done  = 1'b0;
        clr_done  = 1'b0;
        case (state)
            S_IDLE, S_DONE: begin
                if (abort && state == S_DONE) begin
                    flush     = 1'b1;
                    clr_done  = 1'b1;
                    state_nxt = S_IDLE;
                end else if (start && !abort) begin
                    flush    = 1'b1;
                    load     = 1'b1;
                    clr_done = 1'b1;
                    if (length == '0) begin
                        set_done  = 1'b1;
                        state_nxt = S_DONE;
                    end else begin
                        state_nxt = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (abort) begin
                    flush     = 1'b1;
                    clr_done  = 1'b1;
                    state_nxt = S_IDLE;
                end else if (remaining == '0) begin
                    set_done  = 1'b1;
                    state_nxt = S_DONE;
                end else if (count_ap < FULL) begin
                    state_nxt = S_FETCH;
                end
            end
            S_FETCH: begin
                if (ack_evt && abort) begin
                    // Access completed in the abort cycle: nothing left to drain.
                    flush     = 1'b1;
                    state_nxt = S_IDLE;
                end else if (ack_evt) begin
                    push      = 1'b1;
                    advance   = 1'b1;
                    state_nxt = S_WAIT;
                end else if (abort) begin
                    state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (ack_evt) begin
                    flush     = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Head byte presented next cycle, accounting for this cycle's pop and push.
    always_comb begin
        head_nxt = byte_out;
        if (push && count_ap == '0)
            head_nxt = tape_dout;
        else if (count_ap != '0)
            head_nxt = mem[rd_nxt];
    end

    // State, done flag and ack phase tracking.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            done     <= 1'b0;
            ack_seen <= 1'b0;
        end else begin
            state <= state_nxt;
            if (set_done)
                done <= 1'b1;
            else if (clr_done)
                done <= 1'b0;
            if (state == S_IDLE || state == S_DONE || ack_evt)
                ack_seen <= tape_ack;
        end
    end

    // Stream address and remaining byte count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tape_addr <= '0;
            remaining <= '0;
        end else if (load) begin
            tape_addr <= base_addr;
            remaining <= length;
        end else if (advance) begin
            tape_addr <= tape_addr + AW'(1);
            remaining <= remaining - AW'(1);
        end
    end

    // FIFO pointers, occupancy and registered head byte.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            byte_out <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PW'(1);
            rd_ptr   <= rd_nxt;
            count    <= count_ap + {{PW{1'b0}}, push};
            byte_out <= head_nxt;
        end
    end

    // FIFO storage; contents need no reset since occupancy gates visibility.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= tape_dout;
    end

endmodule

// File: tb/tb_tape_stream_reader.sv
// Bench for tape_stream_reader: a behavioural tape-port model answers each
// request with the low address byte after a fixed latency; a scoreboard
// queue holds expected bytes and a negedge monitor pops and compares them.
module tb_tape_stream_reader;

    localparam int AW  = 23;
    localparam int LAT = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [AW-1:0] length = '0;
    logic [AW-1:0] tape_addr;
    logic          tape_rd;
    logic [7:0]    tape_dout = '0;
    logic          tape_ack = 1'b0;
    logic          pop = 1'b0;
    logic [7:0]    byte_out;
    logic          byte_valid;
    logic          busy;
    logic          done;

    int compared = 0;
    int mismatched = 0;

    logic [7:0]    exp_q[$];
    logic [AW-1:0] addr_log[$];
    int            req_cnt = 0;
    int            popped = 0;
    int            pop_allow = 0;
    logic          last_ack = 1'b0;

    tape_stream_reader #(.DEPTH(8), .AW(AW)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .base_addr(base_addr), .length(length),
        .tape_addr(tape_addr), .tape_rd(tape_rd), .tape_dout(tape_dout),
        .tape_ack(tape_ack), .pop(pop), .byte_out(byte_out),
        .byte_valid(byte_valid), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Tape-port model: accept a request, toggle ack LAT cycles later.
    initial begin
        logic          pending;
        int            cnt;
        logic [AW-1:0] a;
        pending = 1'b0;
        cnt = 0;
        a = '0;
        forever begin
            @(posedge clk);
            if (!pending) begin
                if (tape_rd) begin
                    pending = 1'b1;
                    cnt = LAT;
                    a = tape_addr;
                    req_cnt++;
                    addr_log.push_back(tape_addr);
                end
            end else begin
                cnt--;
                if (cnt == 0) begin
                    tape_dout <= a[7:0];
                    tape_ack  <= ~tape_ack;
                    pending = 1'b0;
                end
            end
        end
    end

    // Consumer and scoreboard monitor; also checks the request drops on each ack.
    initial begin
        forever begin
            @(negedge clk);
            if (tape_ack !== last_ack) begin
                check("rd_low_at_ack", {31'd0, tape_rd}, 32'd0);
                last_ack = tape_ack;
            end
            if (!reset && byte_valid && popped < pop_allow) begin
                if (exp_q.size() == 0) begin
                    check("phantom_byte", {24'd0, byte_out}, 32'hFFFF_FFFF);
                end else begin
                    check("byte", {24'd0, byte_out}, {24'd0, exp_q.pop_front()});
                end
                popped++;
                pop = 1'b1;
            end else begin
                pop = 1'b0;
            end
        end
    end

    task automatic start_stream(input logic [AW-1:0] b, input logic [AW-1:0] len);
        logic [AW-1:0] a;
        for (int i = 0; i < int'(len); i++) begin
            a = b + AW'(i);
            exp_q.push_back(a[7:0]);
        end
        @(negedge clk);
        base_addr = b;
        length = len;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int n = 0;
        while (done !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, {31'd0, done}, 32'd1);
    endtask

    task automatic wait_drained(input string name, input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || byte_valid) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, exp_q.size(), 32'd0);
    endtask

    initial begin
        int r0;
        int n;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_tape_rd", {31'd0, tape_rd}, 0);
        check("rst_tape_addr", {9'd0, tape_addr}, 0);
        check("rst_byte_valid", {31'd0, byte_valid}, 0);
        check("rst_byte_out", {24'd0, byte_out}, 0);
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_done", {31'd0, done}, 0);
        reset = 1'b0;
        pop_allow = 1000000;
        repeat (2) @(negedge clk);

        // Basic stream of 4 bytes with continuous consumer
        r0 = req_cnt;
        start_stream(23'h001000, 23'd4);
        wait_done("basic_done", 200);
        check("basic_addr", {9'd0, tape_addr}, 32'h1004);
        check("basic_reqs", req_cnt - r0, 4);
        check("basic_busy", {31'd0, busy}, 0);
        wait_drained("basic_drained", 50);

        // Fill then backpressure
        pop_allow = popped;
        r0 = req_cnt;
        start_stream(23'h000100, 23'd20);
        repeat (150) @(negedge clk);
        check("bp_reqs_full", req_cnt - r0, 8);
        check("bp_rd_low", {31'd0, tape_rd}, 0);
        check("bp_valid", {31'd0, byte_valid}, 1);
        check("bp_busy", {31'd0, busy}, 1);
        pop_allow = popped + 1;
        repeat (30) @(negedge clk);
        check("bp_reqs_one_more", req_cnt - r0, 9);
        pop_allow = 1000000;
        wait_done("bp_done", 600);
        wait_drained("bp_drained", 100);
        check("bp_reqs_total", req_cnt - r0, 20);
        check("bp_addr", {9'd0, tape_addr}, 32'h114);

        // Address wrap
        addr_log.delete();
        start_stream(23'h7FFFFE, 23'd3);
        wait_done("wrap_done", 200);
        wait_drained("wrap_drained", 50);
        check("wrap_nreq", addr_log.size(), 3);
        if (addr_log.size() == 3) begin
            check("wrap_a0", {9'd0, addr_log[0]}, 32'h7FFFFE);
            check("wrap_a1", {9'd0, addr_log[1]}, 32'h7FFFFF);
            check("wrap_a2", {9'd0, addr_log[2]}, 32'h000000);
        end
        check("wrap_end_addr", {9'd0, tape_addr}, 32'h1);

        // Empty stream: done one cycle after start, no request
        r0 = req_cnt;
        @(negedge clk);
        base_addr = 23'h55;
        length = '0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("empty_done", {31'd0, done}, 1);
        check("empty_busy", {31'd0, busy}, 0);
        repeat (5) @(negedge clk);
        check("empty_reqs", req_cnt - r0, 0);
        check("empty_valid", {31'd0, byte_valid}, 0);

        // Start while busy is ignored
        r0 = req_cnt;
        start_stream(23'h000200, 23'd2);
        repeat (3) @(negedge clk);
        check("sb_busy", {31'd0, busy}, 1);
        base_addr = 23'h300;
        length = 23'd5;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("sb_done", 200);
        wait_drained("sb_drained", 50);
        check("sb_reqs", req_cnt - r0, 2);
        check("sb_addr", {9'd0, tape_addr}, 32'h202);

        // Abort during FETCH: in-flight data is discarded
        r0 = req_cnt;
        @(negedge clk);
        base_addr = 23'h400;
        length = 23'd5;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (tape_rd !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("ab_saw_rd", {31'd0, tape_rd}, 1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("ab_drain_busy", {31'd0, busy}, 1);
        check("ab_drain_rd", {31'd0, tape_rd}, 0);
        n = 0;
        while (busy === 1'b1 && n < 30) begin
            @(negedge clk);
            n++;
        end
        check("ab_idle", {31'd0, busy}, 0);
        repeat (3) @(negedge clk);
        check("ab_rd_after", {31'd0, tape_rd}, 0);
        check("ab_empty", {31'd0, byte_valid}, 0);
        check("ab_done", {31'd0, done}, 0);
        check("ab_reqs", req_cnt - r0, 1);
        r0 = req_cnt;
        start_stream(23'h000500, 23'd3);
        wait_done("ab_next_done", 200);
        wait_drained("ab_next_drained", 50);
        check("ab_next_reqs", req_cnt - r0, 3);

        // Async reset mid-FETCH with tape_ack high
        start_stream(23'h000600, 23'd6);
        n = 0;
        while (!(tape_rd === 1'b1 && tape_ack === 1'b1) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("rs_found_fetch_ack1", {30'd0, tape_rd, tape_ack}, 32'h3);
        #2;
        reset = 1'b1;
        exp_q.delete();
        #1;
        check("rs_rd", {31'd0, tape_rd}, 0);
        check("rs_busy", {31'd0, busy}, 0);
        check("rs_valid", {31'd0, byte_valid}, 0);
        check("rs_addr", {9'd0, tape_addr}, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (LAT + 4) @(negedge clk);
        check("rs_idle_valid", {31'd0, byte_valid}, 0);
        r0 = req_cnt;
        start_stream(23'h000700, 23'd2);
        wait_done("rs_done", 200);
        wait_drained("rs_drained", 50);
        check("rs_reqs", req_cnt - r0, 2);
        check("rs_addr_end", {9'd0, tape_addr}, 32'h702);

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
